program_run_ctrl: RTL and testbench
===================================

Name: program_run_ctrl

Overview:
Device-side end of the Start/Ack program-launch handshake between the bench and TopLevel.
- Accepts Start pulses and parks the core while Start is high.
- Loads the program counter with the base address of the next program (P1, P2, P3 in turn), then runs the core until it signals done.
- Raises Ack and reports the run's cycle count.
- Sits in TopLevel between the top-level ports and the PC/fetch logic.

Parameters:
PC_W, 10, program-counter width
CNT_W, 16, cycle-counter width
NUM_PROGS, 3, number of programs launched in rotation (1..4)
P1_BASE, 0, PC start address of program 0
P2_BASE, 128, PC start address of program 1
P3_BASE, 256, PC start address of program 2
P4_BASE, 384, PC start address of program 3 (used only if NUM_PROGS=4)
TIMEOUT, 16'hFFF0, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  launch request from the bench (level, held 1+ cycles)
CoreDone  input  1  halt/done indication from the core's decode
CoreRun  output  1  core enable: PC advances and writes commit only when 1
PcLoad  output  1  one-cycle strobe: PC takes PcLoadVal
PcLoadVal  output  PC_W  start address of the selected program
ProgIdx  output  2  index of the program being, or about to be, run
Ack  output  1  done flag to the bench
CycleCount  output  CNT_W  cycles spent in RUN for the current/last program
TimedOut  output  1  watchdog fired on the last run

Behaviour:
- Reset asserted, asynchronously:
  - state=IDLE, ProgIdx=0, CoreRun=0, PcLoad=0, PcLoadVal=P1_BASE, Ack=0, CycleCount=0, TimedOut=0.
  - Reset mid-run aborts immediately; no Ack is produced and ProgIdx returns to 0.
- All outputs are registered. States: IDLE, ARMED, LAUNCH, RUN, DONE.
- IDLE: Start=1 -> ARMED.
- ARMED:
  - CoreRun=0, Ack=0 (Ack clears on the edge that enters ARMED).
  - Stays while Start=1; Start=0 -> LAUNCH. Launch happens on the Start falling edge.
- LAUNCH: exactly one cycle.
  - PcLoad=1, PcLoadVal=base[ProgIdx], CycleCount cleared to 0, TimedOut cleared.
  - Next state is RUN.
- RUN:
  - CoreRun=1. CycleCount increments every cycle and saturates at all-ones without wrapping.
  - CoreDone=1 sampled -> DONE; CoreRun=0 from that same edge.
  - Start is ignored in RUN; no restart.
- DONE:
  - Ack=1, CoreRun=0, CycleCount frozen.
  - On entry ProgIdx <= (ProgIdx+1) mod NUM_PROGS, so 2 -> 0 when NUM_PROGS=3.
  - Start=1 -> ARMED.
- CoreDone is ignored outside RUN.
- Latency:
  - Start sampled 0 at edge k (in ARMED) -> PcLoad=1 after edge k, CoreRun=1 after edge k+1.
  - CoreDone sampled 1 at edge m -> Ack=1 after edge m, so Ack lags CoreDone by 1 cycle.
- CycleCount equals the number of edges on which the FSM was in RUN, including the edge that sampled CoreDone.
- Start and CoreDone high together in RUN: CoreDone wins -> DONE; the held Start then moves DONE -> ARMED on the next edge.
- Start held high across Reset deassert: IDLE -> ARMED on the first edge, with normal behaviour after that.

Optional Feature:
RUN_WATCHDOG_EN
- Defined: if CycleCount reaches TIMEOUT in RUN with CoreDone=0, the FSM -> DONE, TimedOut=1, Ack=1, and ProgIdx still advances.
- Not defined: no watchdog logic; TimedOut is tied to 0 and RUN lasts until CoreDone.

Test Plan:
1. Reset=1 for 2 cycles, then 0 -> all outputs at reset values, state IDLE, Ack=0, PcLoadVal=0.
2. Start high 1 cycle, then low; CoreDone pulsed 5 cycles after CoreRun rises:
   - PcLoad=1 for 1 cycle with PcLoadVal=0.
   - Ack=1 one cycle after CoreDone; CycleCount=6; ProgIdx=1.
3. Three back-to-back launches:
   - PcLoadVal = 0, 128, 256 in order.
   - After the third run ProgIdx=0.
   - Ack drops the cycle after each Start is seen.
4. Start pulsed during RUN; CoreDone toggled while in IDLE or DONE -> no state change, no extra PcLoad, Ack unaffected.
5. Reset asserted during RUN at CycleCount=3:
   - CoreRun=0 and Ack=0 immediately, without waiting for Clk; ProgIdx=0.
   - A subsequent launch loads PcLoadVal=0.
6. RUN_WATCHDOG_EN defined, TIMEOUT=20, CoreDone held 0 -> after 20 RUN cycles: TimedOut=1, Ack=1, CycleCount=20, ProgIdx advanced.

Source files
------------

// File: rtl/program_run_ctrl.sv
// Start/Ack program launcher: parks the core, loads PC, runs until done.
// Optional RUN_WATCHDOG_EN adds a RUN-cycle watchdog (TIMEOUT).
module program_run_ctrl #(
  parameter int                PC_W      = 10,
  parameter int                CNT_W     = 16,
  parameter int                NUM_PROGS = 3,
  parameter logic [PC_W-1:0]   P1_BASE   = 0,
  parameter logic [PC_W-1:0]   P2_BASE   = 128,
  parameter logic [PC_W-1:0]   P3_BASE   = 256,
  parameter logic [PC_W-1:0]   P4_BASE   = 384,
  parameter logic [CNT_W-1:0]  TIMEOUT   = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             CoreDone,
  output logic             CoreRun,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadVal,
  output logic [1:0]       ProgIdx,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount,
  output logic             TimedOut
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARMED  = 3'd1;
  localparam logic [2:0] LAUNCH = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       idx_nxt;
  logic [PC_W-1:0]  base_sel;
  logic             wd_hit;
  logic             run_end;

  always_comb begin
    cnt_inc = (CycleCount == '1) ? CycleCount : CycleCount + 1'b1;
    idx_nxt = (ProgIdx == 2'(NUM_PROGS - 1)) ? 2'd0 : ProgIdx + 2'd1;
    base_sel = P1_BASE;
    unique case (ProgIdx)
      2'd0: base_sel = P1_BASE;
      2'd1: base_sel = P2_BASE;
      2'd2: base_sel = P3_BASE;
      2'd3: base_sel = P4_BASE;
    endcase
`ifdef RUN_WATCHDOG_EN
    wd_hit = !CoreDone && (cnt_inc >= TIMEOUT);
`else
    wd_hit = 1'b0;
`endif
    run_end = CoreDone || wd_hit;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ProgIdx    <= 2'd0;
      CoreRun    <= 1'b0;
      PcLoad     <= 1'b0;
      PcLoadVal  <= P1_BASE;
      Ack        <= 1'b0;
      CycleCount <= '0;
    end else begin
      PcLoad <= 1'b0;
      case (state)
        IDLE: if (Start) state <= ARMED;
        ARMED: begin
          CoreRun <= 1'b0;
          Ack     <= 1'b0;
          if (!Start) begin
            state      <= LAUNCH;
            PcLoad     <= 1'b1;
            PcLoadVal  <= base_sel;
            CycleCount <= '0;
          end
        end
        LAUNCH: begin
          state   <= RUN;
          CoreRun <= 1'b1;
        end
        RUN: begin
          CycleCount <= cnt_inc;
          if (run_end) begin
            state   <= DONE;
            CoreRun <= 1'b0;
            Ack     <= 1'b1;
            ProgIdx <= idx_nxt;
          end
        end
        DONE: if (Start) begin
          state <= ARMED;
          Ack   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_WATCHDOG_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TimedOut <= 1'b0;
    end else if (state == ARMED && !Start) begin
      TimedOut <= 1'b0;
    end else if (state == RUN && wd_hit) begin
      TimedOut <= 1'b1;
    end
  end
`else
  assign TimedOut = 1'b0;
`endif

endmodule

// File: tb/tb_program_run_ctrl.sv
// Scoreboard bench for program_run_ctrl: launches push expected
// PcLoad/Ack events, a negedge monitor pops and compares them.
module tb_program_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        CoreDone = 1'b0;
  logic        CoreRun;
  logic        PcLoad;
  logic [9:0]  PcLoadVal;
  logic [1:0]  ProgIdx;
  logic        Ack;
  logic [15:0] CycleCount;
  logic        TimedOut;

  program_run_ctrl #(
    .PC_W(10), .CNT_W(16), .NUM_PROGS(3),
    .P1_BASE(10'd0), .P2_BASE(10'd128),
    .P3_BASE(10'd256), .P4_BASE(10'd384),
    .TIMEOUT(16'd20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .CoreDone(CoreDone), .CoreRun(CoreRun),
    .PcLoad(PcLoad), .PcLoadVal(PcLoadVal),
    .ProgIdx(ProgIdx), .Ack(Ack),
    .CycleCount(CycleCount), .TimedOut(TimedOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_ack;
    logic [15:0] val;
    logic [1:0]  idx;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (PcLoad) begin
        if (sb.size() == 0 || sb[0].is_ack) begin
          chk("unexpected_pcload", 32'(PcLoadVal), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("pcload_val", 32'(PcLoadVal), 32'(e.val));
          chk("pcload_idx", 32'(ProgIdx), 32'(e.idx));
        end
      end
      if (Ack && !prev_ack) begin
        if (sb.size() == 0 || !sb[0].is_ack) begin
          chk("unexpected_ack", 32'(CycleCount), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("ack_count", 32'(CycleCount), 32'(e.val));
          chk("ack_idx", 32'(ProgIdx), 32'(e.idx));
          chk("ack_timedout", 32'(TimedOut), 32'(e.to));
          chk("ack_corerun", 32'(CoreRun), 32'd0);
        end
      end
    end
    prev_ack = Ack;
  end

  task automatic push(input bit a, input logic [15:0] v,
                      input logic [1:0] i, input logic t);
    exp_t e;
    e.is_ack = a; e.val = v; e.idx = i; e.to = t;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rst_corerun", 32'(CoreRun), 32'd0);
    chk("rst_pcload", 32'(PcLoad), 32'd0);
    chk("rst_pcval", 32'(PcLoadVal), 32'd0);
    chk("rst_idx", 32'(ProgIdx), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_count", 32'(CycleCount), 32'd0);
    chk("rst_timedout", 32'(TimedOut), 32'd0);
  endtask

  // Start pulse through ARMED/LAUNCH; returns just after CoreRun rises.
  task automatic start_seq();
    bit seen;
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1;
    chk("ack_drop", 32'(Ack), 32'd0);
    Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge Clk); #1;
      seen = CoreRun;
    end
    if (!seen) chk("corerun_timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input int n, input logic [9:0] base,
                        input logic [1:0] idx, input logic [1:0] nidx,
                        input bit poke);
    push(1'b0, 16'(base), idx, 1'b0);
    push(1'b1, 16'(n), nidx, 1'b0);
    start_seq();
    for (int i = 0; i < n - 1; i++) begin
      @(posedge Clk); #1;
      Start = (poke && i == 1);
    end
    Start = 1'b0;
    CoreDone = 1'b1;
    @(posedge Clk); #1 CoreDone = 1'b0;
  endtask

  task automatic toggle_done(input int k);
    for (int i = 0; i < k; i++) begin
      CoreDone = 1'b1;
      @(posedge Clk); #1 CoreDone = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    do_reset();
    toggle_done(2);
    chk("idle_done_corerun", 32'(CoreRun), 32'd0);
    chk("idle_done_ack", 32'(Ack), 32'd0);

    launch(6, 10'd0, 2'd0, 2'd1, 1'b0);

    do_reset();
    launch(4, 10'd0, 2'd0, 2'd1, 1'b0);
    launch(3, 10'd128, 2'd1, 2'd2, 1'b0);
    launch(5, 10'd256, 2'd2, 2'd0, 1'b0);
    @(posedge Clk); #1;
    chk("rot_wrap_idx", 32'(ProgIdx), 32'd0);

    launch(6, 10'd0, 2'd0, 2'd1, 1'b1);
    @(posedge Clk); #1;
    toggle_done(3);
    chk("done_hold_ack", 32'(Ack), 32'd1);
    chk("done_hold_corerun", 32'(CoreRun), 32'd0);
    chk("done_hold_idx", 32'(ProgIdx), 32'd1);

    push(1'b0, 16'd128, 2'd1, 1'b0);
    start_seq();
    repeat (3) @(posedge Clk);
    #1 chk("mid_run_count", 32'(CycleCount), 32'd3);
    #2 Reset = 1'b1;
    #1;
    chk("async_corerun", 32'(CoreRun), 32'd0);
    chk("async_ack", 32'(Ack), 32'd0);
    chk("async_idx", 32'(ProgIdx), 32'd0);
    chk("async_count", 32'(CycleCount), 32'd0);
    chk("async_pcval", 32'(PcLoadVal), 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    launch(4, 10'd0, 2'd0, 2'd1, 1'b0);

`ifdef RUN_WATCHDOG_EN
    begin
      bit got;
      push(1'b0, 16'd128, 2'd1, 1'b0);
      push(1'b1, 16'd20, 2'd2, 1'b1);
      start_seq();
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(posedge Clk); #1;
        got = Ack;
      end
      if (!got) chk("watchdog_timeout", 32'd0, 32'd1);
    end
`endif

    repeat (3) @(posedge Clk);
    #1 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
